// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - hazard, MDU-busy and memory-wait stall controller
//
// Purpose: drives PC and FD/DE/EM/MW pipeline register enables and bubble
// controls of a five-stage pipeline. Resolves, in priority order, data-memory
// wait, then data hazards (Tuse/Tnew) and MDU busy conflicts. Tracks MDU
// occupancy with a small down-counter FSM and keeps a saturating count of
// cycles in which the PC was frozen.
//
// Ports:
//   clk                     pipeline clock, rising edge
//   reset                   asynchronous active-low reset
//   D_rs, D_rt              D-stage source registers
//   D_Tuse_rs, D_Tuse_rt    cycles until D needs rs/rt (3 = unused)
//   D_is_md                 D instruction touches HI/LO or starts the MDU
//   E_A3, M_A3              E/M destination register (0 = none)
//   E_Tnew, M_Tnew          cycles until E/M result is forwardable
//   E_md_start, E_md_div    E instruction starts MDU; 1 = divide
//   dm_wait                 data memory not ready this cycle
//   PC_en..MW_en            register enables
//   DE_reset..MW_reset      synchronous bubble inserts
//   md_busy                 MDU computing
//   stall_cycles            saturating count of PC_en = 0 cycles
module pipeline_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        dm_wait,
  output logic        PC_en,
  output logic        FD_en,
  output logic        DE_en,
  output logic        EM_en,
  output logic        MW_en,
  output logic        DE_reset,
  output logic        EM_reset,
  output logic        MW_reset,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic stall_rs, stall_rt, stall_md, stall;

  // Register $0 never carries a real dependency, so it is excluded up front.
  always_comb begin
    stall_rs = (D_rs != 5'd0) &&
               (((E_A3 == D_rs) && (D_Tuse_rs < E_Tnew)) ||
                ((M_A3 == D_rs) && (D_Tuse_rs < M_Tnew)));
    stall_rt = (D_rt != 5'd0) &&
               (((E_A3 == D_rt) && (D_Tuse_rt < E_Tnew)) ||
                ((M_A3 == D_rt) && (D_Tuse_rt < M_Tnew)));
    // A start sitting in E counts as busy so a following HI/LO reader waits.
    stall_md = D_is_md && ((state_q == BUSY) || E_md_start);
    stall    = stall_rs || stall_rt || stall_md;
  end

  always_comb begin
    PC_en    = 1'b1;
    FD_en    = 1'b1;
    DE_en    = 1'b1;
    EM_en    = 1'b1;
    MW_en    = 1'b1;
    DE_reset = 1'b0;
    EM_reset = 1'b0;
    MW_reset = 1'b0;
    if (dm_wait) begin
      // Freeze everything up to M; writeback receives a bubble so the
      // instruction in W is not retired twice.
      PC_en    = 1'b0;
      FD_en    = 1'b0;
      DE_en    = 1'b0;
      EM_en    = 1'b0;
      MW_reset = 1'b1;
    end else if (stall) begin
      PC_en    = 1'b0;
      FD_en    = 1'b0;
      DE_reset = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      IDLE: begin
        // A start under dm_wait is left for the next cycle: the instruction
        // is held in E and presents the start again.
        if (E_md_start && !dm_wait) begin
          state_d = BUSY;
          count_d = E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        // The MDU keeps computing through memory waits.
        if (count_q <= CNT_W'(1)) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    if (!PC_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign md_busy      = (state_q == BUSY);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_is_md, E_md_start, E_md_div, dm_wait;
  logic        PC_en, FD_en, DE_en, EM_en, MW_en;
  logic        DE_reset, EM_reset, MW_reset, md_busy;
  logic [31:0] stall_cycles;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: remaining MDU busy cycles and PC-frozen cycle count.
  int          m_busy_left = 0;
  longint      m_stalls    = 0;

  pipeline_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_is_md(D_is_md), .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div), .dm_wait(dm_wait),
    .PC_en(PC_en), .FD_en(FD_en), .DE_en(DE_en), .EM_en(EM_en), .MW_en(MW_en),
    .DE_reset(DE_reset), .EM_reset(EM_reset), .MW_reset(MW_reset),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {PC_en, FD_en, DE_en, EM_en, MW_en, DE_reset, EM_reset, MW_reset, md_busy}
  function automatic logic [8:0] dut_v();
    return {PC_en, FD_en, DE_en, EM_en, MW_en, DE_reset, EM_reset, MW_reset, md_busy};
  endfunction

  function automatic bit uses_hazard(logic [4:0] r, logic [1:0] tuse);
    if (r == 5'd0) return 1'b0;
    if ((E_A3 == r) && (int'(tuse) < int'(E_Tnew))) return 1'b1;
    if ((M_A3 == r) && (int'(tuse) < int'(M_Tnew))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] exp_v();
    bit busy, hz;
    busy = (m_busy_left > 0);
    hz = uses_hazard(D_rs, D_Tuse_rs) || uses_hazard(D_rt, D_Tuse_rt) ||
         (D_is_md && (busy || E_md_start));
    if (dm_wait)  return {8'b0000_1001, busy};
    else if (hz)  return {8'b0011_1100, busy};
    else          return {8'b1111_1000, busy};
  endfunction

  task automatic clear_inputs();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_is_md = 0;
    E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0;
    E_md_start = 0; E_md_div = 0; dm_wait = 0;
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic step();
    logic [8:0] e;
    e = exp_v();
    @(posedge clk);
    if (reset) begin
      if (!e[8] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (m_busy_left > 0) m_busy_left--;
      else if (E_md_start && !dm_wait) m_busy_left = E_md_div ? 10 : 5;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #3;
    n_checks++;
    if (dut_v() !== 9'b1111_1000_0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want %b", dut_v(), 9'b1111_1000_0);
    end
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1;
    @(negedge clk);
    n_checks++;
    if (dut_v() !== 9'b0011_1100_0) begin
      n_fail++; $display("FAIL load_use_stall: got %b want %b", dut_v(), 9'b0011_1100_0);
    end
    step();
    E_A3 = 5'd0; E_Tnew = 2'd0; M_A3 = 5'd8; M_Tnew = 2'd1;
    @(negedge clk);
    n_checks++;
    if (dut_v() !== 9'b1111_1000_0) begin
      n_fail++; $display("FAIL load_use_release: got %b want %b", dut_v(), 9'b1111_1000_0);
    end
    step();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    E_A3 = 5'd0; E_Tnew = 2'd2; D_rs = 5'd0; D_Tuse_rs = 2'd0;
    @(negedge clk);
    n_checks++;
    if (dut_v() !== 9'b1111_1000_0) begin
      n_fail++; $display("FAIL zero_reg: got %b want %b", dut_v(), 9'b1111_1000_0);
    end
    step();
  endtask

  task automatic test_multiply();
    int busy_n = 0, bubble_n = 0;
    clear_inputs();
    D_is_md = 1'b1; E_md_start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_v() !== exp_v()) begin
        n_fail++; $display("FAIL mult_cycle%0d: got %b want %b", k, dut_v(), exp_v());
      end
      if (md_busy) busy_n++;
      if (DE_reset) bubble_n++;
      step();
      E_md_start = 1'b0;
    end
    n_checks++;
    if (busy_n != 5) begin n_fail++; $display("FAIL mult_busy_len: got %0d want 5", busy_n); end
    n_checks++;
    if (bubble_n != 6) begin n_fail++; $display("FAIL mult_bubbles: got %0d want 6", bubble_n); end
  endtask

  task automatic test_div_dm_wait();
    int busy_n = 0;
    logic [31:0] s0;
    clear_inputs();
    s0 = stall_cycles;
    E_md_start = 1'b1; E_md_div = 1'b1;
    step();
    E_md_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      dm_wait = (k >= 2 && k < 5);
      @(negedge clk);
      n_checks++;
      if (dut_v() !== exp_v()) begin
        n_fail++; $display("FAIL div_cycle%0d: got %b want %b", k, dut_v(), exp_v());
      end
      if (dm_wait) begin
        n_checks++;
        if (MW_reset !== 1'b1 || EM_en !== 1'b0) begin
          n_fail++; $display("FAIL div_wait_ctrl: got MW_reset=%b EM_en=%b want 1 0", MW_reset, EM_en);
        end
      end
      if (md_busy) busy_n++;
      step();
    end
    dm_wait = 1'b0;
    n_checks++;
    if (busy_n != 10) begin n_fail++; $display("FAIL div_busy_len: got %0d want 10", busy_n); end
    n_checks++;
    if (stall_cycles - s0 !== 32'd3) begin
      n_fail++; $display("FAIL div_stall_delta: got %0d want 3", stall_cycles - s0);
    end
  endtask

  task automatic test_start_during_wait();
    int busy_n = 0;
    clear_inputs();
    E_md_start = 1'b1; dm_wait = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      n_checks++;
      if (md_busy !== 1'b0) begin
        n_fail++; $display("FAIL start_wait_busy%0d: got %b want 0", k, md_busy);
      end
    end
    dm_wait = 1'b0;
    step();
    E_md_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (md_busy) busy_n++;
      step();
    end
    n_checks++;
    if (busy_n != 5) begin n_fail++; $display("FAIL start_wait_len: got %0d want 5", busy_n); end
  endtask

  task automatic test_async_reset();
    int busy_n = 0;
    clear_inputs();
    E_md_start = 1'b1; E_md_div = 1'b1; D_is_md = 1'b1;
    step();
    E_md_start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    #2;
    reset = 1'b0;
    m_busy_left = 0; m_stalls = 0;
    #1;
    n_checks++;
    if (md_busy !== 1'b0 || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: got busy=%b stalls=%0d want 0 0", md_busy, stall_cycles);
    end
    @(negedge clk);
    reset = 1'b1;
    D_is_md = 1'b0;
    E_md_start = 1'b1;
    step();
    E_md_start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (md_busy) busy_n++;
      step();
    end
    n_checks++;
    if (busy_n != 10) begin n_fail++; $display("FAIL reset_reload_len: got %0d want 10", busy_n); end
  endtask

  task automatic test_random();
    clear_inputs();
    for (int k = 0; k < 400; k++) begin
      D_rs = 5'($urandom_range(0, 3));      D_rt = 5'($urandom_range(0, 3));
      E_A3 = 5'($urandom_range(0, 3));      M_A3 = 5'($urandom_range(0, 3));
      D_Tuse_rs = 2'($urandom);             D_Tuse_rt = 2'($urandom);
      E_Tnew = 2'($urandom);                M_Tnew = 2'($urandom);
      D_is_md = ($urandom_range(0, 3) == 0);
      E_md_start = ($urandom_range(0, 7) == 0);
      E_md_div = 1'($urandom);
      dm_wait = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      n_checks++;
      if (dut_v() !== exp_v()) begin
        n_fail++; $display("FAIL rand_ctrl%0d: got %b want %b", k, dut_v(), exp_v());
      end
      n_checks++;
      if (stall_cycles !== 32'(m_stalls)) begin
        n_fail++; $display("FAIL rand_stalls%0d: got %0d want %0d", k, stall_cycles, m_stalls);
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_multiply();
    test_div_dm_wait();
    test_start_during_wait();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
